// File: rtl/bsg_manycore_gs_store_engine.sv
// Scatter-side store engine: buffers returned load words and issues one remote store per word, then a signal store.
// Optional stall statistics counter enabled by defining BSG_MANYCORE_GS_STORE_STATS_EN.
module bsg_manycore_gs_store_engine #(
  parameter int x_cord_width_p  = 8,
  parameter int y_cord_width_p  = 8,
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 32,
  parameter int load_id_width_p = 11,
  parameter int fifo_els_p      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [data_width_p-1:0]    dst_addr_i,
  input  logic [x_cord_width_p-1:0]  dst_x_i,
  input  logic [y_cord_width_p-1:0]  dst_y_i,
  input  logic [load_id_width_p-1:0] word_len_i,
  input  logic [data_width_p-1:0]    sig_addr_i,
  input  logic                       in_v_i,
  input  logic [data_width_p-1:0]    in_data_i,
  input  logic [load_id_width_p-1:0] in_id_i,
  output logic                       in_ready_o,
  output logic                       out_v_o,
  output logic [addr_width_p-1:0]    out_addr_o,
  output logic [data_width_p-1:0]    out_data_o,
  output logic [x_cord_width_p-1:0]  out_x_o,
  output logic [y_cord_width_p-1:0]  out_y_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [31:0]                stall_cnt_o
);

  localparam int ptr_w = $clog2(fifo_els_p);

  typedef enum logic [1:0] {IDLE, STORE, SIGNAL} state_t;
  state_t state, state_n;

  logic [data_width_p-1:0]    fifo_data [fifo_els_p];
  logic [load_id_width_p-1:0] fifo_id   [fifo_els_p];
  logic [ptr_w:0]             wr_ptr, rd_ptr;
  logic                       full, empty, push, pop, latch, accept;

  logic [addr_width_p-1:0]    dst_word, sig_word, store_addr;
  logic [x_cord_width_p-1:0]  dst_x;
  logic [y_cord_width_p-1:0]  dst_y;
  logic [load_id_width_p-1:0] len, cnt;
  logic [data_width_p-1:0]    head_data;
  logic [load_id_width_p-1:0] head_id;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) &&
                      (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);
  assign in_ready_o = ~full;
  assign push       = in_v_i & in_ready_o;
  assign head_data  = fifo_data[rd_ptr[ptr_w-1:0]];
  assign head_id    = fifo_id[rd_ptr[ptr_w-1:0]];
  assign store_addr = dst_word + addr_width_p'(head_id);
  assign accept     = out_v_o & out_ready_i;
  assign out_x_o    = dst_x;
  assign out_y_o    = dst_y;

  always_comb begin
    state_n    = state;
    out_v_o    = 1'b0;
    out_addr_o = '0;
    out_data_o = '0;
    busy_o     = (state != IDLE);
    pop        = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          latch   = 1'b1;
          state_n = (word_len_i == '0) ? SIGNAL : STORE;
        end
      end
      STORE: begin
        out_v_o    = ~empty;
        out_addr_o = store_addr;
        out_data_o = head_data;
        if (~empty && out_ready_i) begin
          pop = 1'b1;
          if (cnt == load_id_width_p'(len - 1'b1)) state_n = SIGNAL;
        end
      end
      SIGNAL: begin
        out_v_o    = 1'b1;
        out_addr_o = sig_word;
        out_data_o = data_width_p'(1);
        if (out_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      len      <= '0;
      dst_word <= '0;
      sig_word <= '0;
      dst_x    <= '0;
      dst_y    <= '0;
      done_o   <= 1'b0;
    end else begin
      state  <= state_n;
      done_o <= (state == SIGNAL) && out_ready_i;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= cnt + 1'b1;
      end
      if (latch) begin
        cnt      <= '0;
        len      <= word_len_i;
        dst_word <= addr_width_p'(dst_addr_i >> 2);
        sig_word <= addr_width_p'(sig_addr_i >> 2);
        dst_x    <= dst_x_i;
        dst_y    <= dst_y_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr[ptr_w-1:0]] <= in_data_i;
      fifo_id[wr_ptr[ptr_w-1:0]]   <= in_id_i;
    end
  end

`ifdef BSG_MANYCORE_GS_STORE_STATS_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                           stall_cnt <= '0;
    else if (latch)                                        stall_cnt <= '0;
    else if (out_v_o && !out_ready_i && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
  end
  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i) !(in_v_i && full));
  a_id_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
                                  (state == STORE && !empty) |-> (head_id < len));

  logic unused;
  assign unused = accept;

endmodule

// File: tb/tb_bsg_manycore_gs_store_engine.sv
// Directed bench for the gather/scatter store engine with a scoreboard of expected stores.
module tb_bsg_manycore_gs_store_engine;
  logic        clk_i = 1'b0, reset_i = 1'b1, start_i = 1'b0;
  logic [31:0] dst_addr_i = '0, sig_addr_i = '0, in_data_i = '0;
  logic [3:0]  dst_x_i = '0, dst_y_i = '0;
  logic [10:0] word_len_i = '0, in_id_i = '0;
  logic        in_v_i = 1'b0, out_ready_i = 1'b1;
  logic        in_ready_o, out_v_o, busy_o, done_o;
  logic [31:0] out_addr_o, out_data_o, stall_cnt_o;
  logic [3:0]  out_x_o, out_y_o;

  bsg_manycore_gs_store_engine #(
    .x_cord_width_p(4), .y_cord_width_p(4), .data_width_p(32),
    .addr_width_p(32), .load_id_width_p(11), .fifo_els_p(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .dst_addr_i(dst_addr_i), .dst_x_i(dst_x_i), .dst_y_i(dst_y_i),
    .word_len_i(word_len_i), .sig_addr_i(sig_addr_i),
    .in_v_i(in_v_i), .in_data_i(in_data_i), .in_id_i(in_id_i), .in_ready_o(in_ready_o),
    .out_v_o(out_v_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  x;
    logic [3:0]  y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_checks = 0, n_fail = 0, done_cnt = 0, store_cnt = 0;
  logic [31:0] exp_base, exp_sig;
  logic [3:0]  exp_x, exp_y;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (done_o) done_cnt++;
      if (out_v_o && out_ready_i) begin
        store_cnt++;
        if (sb.size() == 0) check("unexpected_store", out_addr_o, 64'hdead);
        else begin
          mon_e = sb.pop_front();
          check("out_addr", out_addr_o, mon_e.addr);
          check("out_data", out_data_o, mon_e.data);
          check("out_x", out_x_o, mon_e.x);
          check("out_y", out_y_o, mon_e.y);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic add_signal_exp();
    exp_t e;
    e.addr = exp_sig; e.data = 32'd1; e.x = exp_x; e.y = exp_y;
    sb.push_back(e);
  endtask

  task automatic begin_xfer(logic [31:0] dst, logic [3:0] x, logic [3:0] y,
                            logic [10:0] len, logic [31:0] sig);
    exp_base = dst >> 2; exp_sig = sig >> 2; exp_x = x; exp_y = y;
    if (len == 0) add_signal_exp();
    dst_addr_i = dst; dst_x_i = x; dst_y_i = y; word_len_i = len; sig_addr_i = sig;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic push_word(logic [10:0] id, logic [31:0] data);
    exp_t e;
    int n = 0;
    while (!in_ready_o && n < 200) begin tick(); n++; end
    check("push_ready", in_ready_o, 1);
    e.addr = exp_base + 32'(id); e.data = data; e.x = exp_x; e.y = exp_y;
    sb.push_back(e);
    in_v_i = 1'b1; in_id_i = id; in_data_i = data;
    tick();
    in_v_i = 1'b0;
  endtask

  task automatic wait_done(int target, string tag);
    int n = 0;
    while (done_cnt < target && n < 200) begin tick(); n++; end
    tick();
    check({tag, "_done_cnt"}, done_cnt, target);
    check({tag, "_idle"}, busy_o, 0);
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    int s0, d0;
    logic [31:0] exp_stall;
    #1;
    check("rst_out_v", out_v_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_stall", stall_cnt_o, 0);
    tick(); tick();
    reset_i = 1'b0;
    tick();

    // In-order transfer
    begin_xfer(32'h1000, 4'd1, 4'd2, 11'd4, 32'h2000);
    for (int i = 0; i < 4; i++) push_word(11'(i), 32'h11110000 + 32'(i));
    add_signal_exp();
    wait_done(1, "inorder");

    // Out-of-order ids map to addresses by id
    begin_xfer(32'h1000, 4'd1, 4'd2, 11'd4, 32'h2000);
    push_word(11'd3, 32'hA);
    push_word(11'd1, 32'hB);
    push_word(11'd0, 32'hC);
    push_word(11'd2, 32'hD);
    add_signal_exp();
    wait_done(2, "ooo");

    // Zero-length transfer: signal only, done two cycles after start
    begin_xfer(32'h1000, 4'd1, 4'd2, 11'd0, 32'h2000);
    check("len0_out_v", out_v_o, 1);
    check("len0_addr", out_addr_o, 32'h800);
    tick();
    check("len0_done_pulse", done_o, 1);
    tick();
    check("len0_done_low", done_o, 0);
    check("len0_idle", busy_o, 0);
    check("len0_done_cnt", done_cnt, 3);

    // Backpressure: buffer fills, outputs hold, stalls counted
    out_ready_i = 1'b0;
    begin_xfer(32'h3000, 4'd3, 4'd1, 11'd4, 32'h4000);
    check("bp_empty_no_v", out_v_o, 0);
    push_word(11'd0, 32'h55);
    check("bp_latency_v", out_v_o, 1);
    for (int i = 1; i < 4; i++) push_word(11'(i), 32'h55 + 32'(i));
    check("bp_full", in_ready_o, 0);
    for (int i = 0; i < 7; i++) begin
      check("bp_hold_v", out_v_o, 1);
      check("bp_hold_addr", out_addr_o, 32'hC00);
      check("bp_hold_data", out_data_o, 32'h55);
      check("bp_hold_x", out_x_o, 3);
      check("bp_hold_y", out_y_o, 1);
      tick();
    end
`ifdef BSG_MANYCORE_GS_STORE_STATS_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    check("bp_stall_cnt", stall_cnt_o, exp_stall);
    add_signal_exp();
    out_ready_i = 1'b1;
    wait_done(4, "bp");
    check("bp_stall_hold", stall_cnt_o, exp_stall);

    // start_i while busy is ignored
    s0 = store_cnt;
    begin_xfer(32'h100, 4'd5, 4'd6, 11'd2, 32'h200);
    check("busy_start_clears_stall", stall_cnt_o, 0);
    dst_addr_i = 32'hF00; dst_x_i = 4'd7; dst_y_i = 4'd8; word_len_i = 11'd1; sig_addr_i = 32'hE00;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("ignored_start_busy", busy_o, 1);
    push_word(11'd0, 32'h1234);
    push_word(11'd1, 32'h5678);
    add_signal_exp();
    wait_done(5, "ignored");
    check("ignored_store_count", store_cnt - s0, 3);

    // Reset mid-transfer with two words buffered
    out_ready_i = 1'b0;
    begin_xfer(32'h5000, 4'd2, 4'd3, 11'd4, 32'h6000);
    push_word(11'd0, 32'h99);
    push_word(11'd1, 32'h9A);
    check("mid_v", out_v_o, 1);
    d0 = done_cnt;
    reset_i = 1'b1;
    #1;
    check("mid_rst_v", out_v_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ready", in_ready_o, 1);
    check("mid_rst_done", done_o, 0);
    sb.delete();
    tick(); tick();
    reset_i = 1'b0;
    out_ready_i = 1'b1;
    tick(); tick();
    check("post_rst_v", out_v_o, 0);
    check("post_rst_no_done", done_cnt, d0);
    begin_xfer(32'h5000, 4'd2, 4'd3, 11'd1, 32'h6000);
    push_word(11'd0, 32'h77);
    add_signal_exp();
    wait_done(d0 + 1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
